// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and pipe_hazard_ctrl.
// StallCount is present only when HAZ_PERF_CNT_EN is defined.
interface pipe_hazard_ctrl_if;
    logic [4:0]  RegisterRsD;
    logic [4:0]  RegisterRtD;
    logic [4:0]  RegisterRsE;
    logic [4:0]  RegisterRtE;
    logic [4:0]  WriteRegE;
    logic [4:0]  WriteRegM;
    logic [4:0]  WriteRegW;
    logic        RegWriteE;
    logic        RegWriteM;
    logic        RegWriteW;
    logic        MemtoRegE;
    logic        MemtoRegM;
    logic        BranchD;
    logic        PCSrcD;
    logic        MdStartD;
    logic        MdStartE;
    logic        HiLoReadD;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic        FlushE;
    logic [1:0]  ForwardAE;
    logic [1:0]  ForwardBE;
    logic        ForwardAD;
    logic        ForwardBD;
    logic        MdBusy;
    logic        MdDone;
    logic        MdOverlap;
    logic        MdStateDbg;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] StallCount;
`endif

    modport master (
`ifdef HAZ_PERF_CNT_EN
        input  StallCount,
`endif
        output RegisterRsD, RegisterRtD, RegisterRsE, RegisterRtE,
        output WriteRegE, WriteRegM, WriteRegW,
        output RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
        output BranchD, PCSrcD, MdStartD, MdStartE, HiLoReadD,
        input  StallF, StallD, FlushD, FlushE,
        input  ForwardAE, ForwardBE, ForwardAD, ForwardBD,
        input  MdBusy, MdDone, MdOverlap, MdStateDbg
    );

    modport slave (
`ifdef HAZ_PERF_CNT_EN
        output StallCount,
`endif
        input  RegisterRsD, RegisterRtD, RegisterRsE, RegisterRtE,
        input  WriteRegE, WriteRegM, WriteRegW,
        input  RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
        input  BranchD, PCSrcD, MdStartD, MdStartE, HiLoReadD,
        output StallF, StallD, FlushD, FlushE,
        output ForwardAE, ForwardBE, ForwardAD, ForwardBD,
        output MdBusy, MdDone, MdOverlap, MdStateDbg
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward control for the 5-stage pipeline plus the mult/div busy sequencer.
// Defining HAZ_PERF_CNT_EN adds a saturating 32-bit stall-cycle counter (StallCount).
module pipe_hazard_ctrl #(
    parameter int MD_LATENCY = 32
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave hz
);
    typedef enum logic {IDLE, BUSY} md_state_t;

    localparam logic [7:0] MD_LOAD = 8'(MD_LATENCY);

    md_state_t  state;
    logic [7:0] md_cnt;
    logic       md_busy;
    logic       md_done;
    logic       md_overlap;

    logic m_fwd_ok;
    logic w_fwd_ok;
    logic lwstall;
    logic branchstall;
    logic mdstall;
    logic stall;

    assign m_fwd_ok = hz.RegWriteM && (hz.WriteRegM != 5'd0);
    assign w_fwd_ok = hz.RegWriteW && (hz.WriteRegW != 5'd0);

    always_comb begin
        hz.ForwardAE = 2'b00;
        if (m_fwd_ok && hz.WriteRegM == hz.RegisterRsE)
            hz.ForwardAE = 2'b10;
        else if (w_fwd_ok && hz.WriteRegW == hz.RegisterRsE)
            hz.ForwardAE = 2'b01;
    end

    always_comb begin
        hz.ForwardBE = 2'b00;
        if (m_fwd_ok && hz.WriteRegM == hz.RegisterRtE)
            hz.ForwardBE = 2'b10;
        else if (w_fwd_ok && hz.WriteRegW == hz.RegisterRtE)
            hz.ForwardBE = 2'b01;
    end

    assign hz.ForwardAD = m_fwd_ok && (hz.WriteRegM == hz.RegisterRsD);
    assign hz.ForwardBD = m_fwd_ok && (hz.WriteRegM == hz.RegisterRtD);

    assign lwstall = hz.MemtoRegE && (hz.RegisterRtE != 5'd0) &&
                     ((hz.RegisterRtE == hz.RegisterRsD) || (hz.RegisterRtE == hz.RegisterRtD));

    // The branch comparator lives in D, so any producer still in E, or a load in M, must drain first.
    assign branchstall = hz.BranchD && (
        (hz.RegWriteE && (hz.WriteRegE != 5'd0) &&
         ((hz.WriteRegE == hz.RegisterRsD) || (hz.WriteRegE == hz.RegisterRtD))) ||
        (hz.MemtoRegM && (hz.WriteRegM != 5'd0) &&
         ((hz.WriteRegM == hz.RegisterRsD) || (hz.WriteRegM == hz.RegisterRtD))));

    assign mdstall = md_busy && (hz.HiLoReadD || hz.MdStartD);
    assign stall   = lwstall || branchstall || mdstall;

    assign hz.StallF = stall;
    assign hz.StallD = stall;
    assign hz.FlushE = stall;
    assign hz.FlushD = hz.PCSrcD && !stall;

    // Counter is loaded with the latency and the busy period ends on the edge where it reads 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            md_cnt     <= 8'd0;
            md_busy    <= 1'b0;
            md_done    <= 1'b0;
            md_overlap <= 1'b0;
        end else begin
            md_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hz.MdStartE) begin
                        state   <= BUSY;
                        md_cnt  <= MD_LOAD;
                        md_busy <= 1'b1;
                    end
                end
                BUSY: begin
                    md_cnt <= md_cnt - 8'd1;
                    if (hz.MdStartE)
                        md_overlap <= 1'b1;
                    if (md_cnt == 8'd1) begin
                        state   <= IDLE;
                        md_busy <= 1'b0;
                        md_done <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    md_busy <= 1'b0;
                end
            endcase
        end
    end

    assign hz.MdBusy     = md_busy;
    assign hz.MdDone     = md_done;
    assign hz.MdOverlap  = md_overlap;
    assign hz.MdStateDbg = (state == BUSY);

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt <= 32'd0;
        else if (stall && stall_cnt != 32'hFFFF_FFFF)
            stall_cnt <= stall_cnt + 32'd1;
    end

    assign hz.StallCount = stall_cnt;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: combinational vector table plus mult/div sequencing cases.
module tb_pipe_hazard_ctrl;
    typedef struct {
        logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
        logic       rw_e, rw_m, rw_w, m2r_e, m2r_m, br_d, pcsrc_d, hilo_d, mds_d;
        logic [9:0] exp;   // {StallF,StallD,FlushD,FlushE,ForwardAE,ForwardBE,ForwardAD,ForwardBD}
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    vec_t tbl[$];

    pipe_hazard_ctrl_if hif();

    pipe_hazard_ctrl #(.MD_LATENCY(4)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hif.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t blank();
        vec_t v;
        v = '{default: '0};
        return v;
    endfunction

    task automatic clear_inputs();
        hif.RegisterRsD = 5'd0; hif.RegisterRtD = 5'd0;
        hif.RegisterRsE = 5'd0; hif.RegisterRtE = 5'd0;
        hif.WriteRegE = 5'd0; hif.WriteRegM = 5'd0; hif.WriteRegW = 5'd0;
        hif.RegWriteE = 1'b0; hif.RegWriteM = 1'b0; hif.RegWriteW = 1'b0;
        hif.MemtoRegE = 1'b0; hif.MemtoRegM = 1'b0;
        hif.BranchD = 1'b0; hif.PCSrcD = 1'b0;
        hif.MdStartD = 1'b0; hif.MdStartE = 1'b0; hif.HiLoReadD = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        hif.RegisterRsD = v.rs_d; hif.RegisterRtD = v.rt_d;
        hif.RegisterRsE = v.rs_e; hif.RegisterRtE = v.rt_e;
        hif.WriteRegE = v.wr_e; hif.WriteRegM = v.wr_m; hif.WriteRegW = v.wr_w;
        hif.RegWriteE = v.rw_e; hif.RegWriteM = v.rw_m; hif.RegWriteW = v.rw_w;
        hif.MemtoRegE = v.m2r_e; hif.MemtoRegM = v.m2r_m;
        hif.BranchD = v.br_d; hif.PCSrcD = v.pcsrc_d;
        hif.HiLoReadD = v.hilo_d; hif.MdStartD = v.mds_d;
        hif.MdStartE = 1'b0;
    endtask

    function automatic logic [9:0] comb_out();
        return {hif.StallF, hif.StallD, hif.FlushD, hif.FlushE,
                hif.ForwardAE, hif.ForwardBE, hif.ForwardAD, hif.ForwardBD};
    endfunction

    function automatic logic [4:0] md_out();
        return {hif.MdBusy, hif.MdDone, hif.MdOverlap, hif.StallD, hif.MdStateDbg};
    endfunction

    task automatic build_table();
        vec_t v;
        v = blank(); v.m2r_e = 1; v.rt_e = 5; v.rs_d = 5; v.exp = 10'b1101_00_00_00; tbl.push_back(v);
        v = blank(); v.m2r_e = 1; v.rt_e = 0; v.rs_d = 0; v.exp = 10'b0000_00_00_00; tbl.push_back(v);
        v = blank(); v.m2r_e = 1; v.rt_e = 9; v.rt_d = 9; v.exp = 10'b1101_00_00_00; tbl.push_back(v);
        v = blank(); v.rw_m = 1; v.wr_m = 3; v.rw_w = 1; v.wr_w = 3; v.rs_e = 3;
        v.exp = 10'b0000_10_00_00; tbl.push_back(v);
        v = blank(); v.rw_m = 0; v.wr_m = 3; v.rw_w = 1; v.wr_w = 3; v.rs_e = 3;
        v.exp = 10'b0000_01_00_00; tbl.push_back(v);
        v = blank(); v.rw_m = 0; v.wr_m = 3; v.rw_w = 1; v.wr_w = 0; v.rs_e = 3;
        v.exp = 10'b0000_00_00_00; tbl.push_back(v);
        v = blank(); v.rw_m = 1; v.wr_m = 4; v.rt_e = 4; v.rw_w = 1; v.wr_w = 6; v.rs_e = 6;
        v.exp = 10'b0000_01_10_00; tbl.push_back(v);
        v = blank(); v.rw_m = 1; v.wr_m = 0; v.rw_w = 1; v.wr_w = 0;
        v.exp = 10'b0000_00_00_00; tbl.push_back(v);
        v = blank(); v.rw_m = 1; v.wr_m = 8; v.rs_d = 8; v.rt_d = 8;
        v.exp = 10'b0000_00_00_11; tbl.push_back(v);
        v = blank(); v.br_d = 1; v.rw_e = 1; v.wr_e = 7; v.rt_d = 7; v.pcsrc_d = 1;
        v.exp = 10'b1101_00_00_00; tbl.push_back(v);
        v = blank(); v.br_d = 1; v.rw_e = 1; v.wr_e = 7; v.rt_d = 6; v.pcsrc_d = 1;
        v.exp = 10'b0010_00_00_00; tbl.push_back(v);
        v = blank(); v.br_d = 1; v.m2r_m = 1; v.wr_m = 2; v.rs_d = 2;
        v.exp = 10'b1101_00_00_00; tbl.push_back(v);
        v = blank(); v.br_d = 1; v.rw_e = 0; v.wr_e = 7; v.rt_d = 7;
        v.exp = 10'b0000_00_00_00; tbl.push_back(v);
        v = blank(); v.br_d = 1; v.rw_e = 1; v.wr_e = 0;
        v.exp = 10'b0000_00_00_00; tbl.push_back(v);
        v = blank(); v.rw_e = 1; v.wr_e = 7; v.rt_d = 7;
        v.exp = 10'b0000_00_00_00; tbl.push_back(v);
        v = blank(); v.hilo_d = 1; v.mds_d = 1;
        v.exp = 10'b0000_00_00_00; tbl.push_back(v);
        v = blank(); v.m2r_e = 1; v.rt_e = 5; v.rs_d = 5; v.pcsrc_d = 1;
        v.exp = 10'b1101_00_00_00; tbl.push_back(v);
        v = blank(); v.pcsrc_d = 1;
        v.exp = 10'b0010_00_00_00; tbl.push_back(v);
    endtask

    initial begin
        logic exp_busy;
        logic exp_done;
        logic exp_ovl;

        clear_inputs();
        build_table();

        // Clock/reset
        repeat (2) @(negedge clk);
        #1;
        check("reset md state", {27'd0, md_out()}, 32'd0);
`ifdef HAZ_PERF_CNT_EN
        check("reset StallCount", hif.StallCount, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;

        // Combinational vector table, sequencer idle
        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            check($sformatf("vec %0d", i), {22'd0, comb_out()}, {22'd0, tbl[i].exp});
        end
        @(negedge clk);
        clear_inputs();

        // Single MD op with mfhi held in D
        @(negedge clk);
        hif.MdStartE = 1'b1;
        hif.HiLoReadD = 1'b1;
        #1;
        check("hilo idle no stall", {31'd0, hif.StallD}, 32'd0);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            hif.MdStartE = 1'b0;
            #1;
            exp_busy = (k <= 4);
            exp_done = (k == 5);
            check($sformatf("md single k=%0d", k), {27'd0, md_out()},
                  {27'd0, exp_busy, exp_done, 1'b0, exp_busy, exp_busy});
        end
        hif.HiLoReadD = 1'b0;

        // Overlapping start in BUSY, then back-to-back restart in the done cycle
        @(negedge clk);
        hif.MdStartE = 1'b1;
        hif.MdStartD = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk);
            @(negedge clk);
            hif.MdStartE = (k == 2 || k == 5);
            #1;
            exp_busy = (k <= 4) || (k >= 6 && k <= 9);
            exp_done = (k == 5) || (k == 10);
            exp_ovl  = (k >= 3);
            check($sformatf("md b2b k=%0d", k), {27'd0, md_out()},
                  {27'd0, exp_busy, exp_done, exp_ovl, exp_busy, exp_busy});
        end
        hif.MdStartD = 1'b0;

        // Asynchronous reset in the middle of a busy period
        @(negedge clk);
        hif.MdStartE = 1'b1;
        @(posedge clk);
        @(negedge clk);
        hif.MdStartE = 1'b0;
        #1;
        check("busy before reset", {27'd0, md_out()}, {27'd0, 5'b10101});
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async reset clears", {27'd0, md_out()}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("no done after reset k=%0d", k), {27'd0, md_out()}, 32'd0);
        end

`ifdef HAZ_PERF_CNT_EN
        // Three load-use stall cycles plus four md stall cycles
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        hif.MemtoRegE = 1'b1;
        hif.RegisterRtE = 5'd5;
        hif.RegisterRsD = 5'd5;
        repeat (3) @(negedge clk);
        clear_inputs();
        hif.MdStartE = 1'b1;
        hif.HiLoReadD = 1'b1;
        @(negedge clk);
        hif.MdStartE = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        check("StallCount", hif.StallCount, 32'd7);
        clear_inputs();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
